// File: rtl/spi_pkg.sv
// Shared SPI link definitions: FSM state encoding and default geometry,
// common to the spi_slave_rx_tx responder and the SPI_main master.
package spi_pkg;

    localparam int unsigned SPI_DATA_W      = 8;
    localparam int unsigned SPI_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with single-cycle
// rise/fall pulses derived from the synchronized value.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    always_comb begin
        level = sync_q[STAGES-1];
        rise  = level & ~prev_q;
        fall  = ~level & prev_q;
    end

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder, MSB first: oversamples sclk/ss/mosi on global_clk,
// assembles received words and shifts a host-loaded word out on miso.
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int unsigned        DATA_W      = SPI_DATA_W,
    parameter int unsigned        SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic [DATA_W-1:0]  IDLE_TX     = '0
) (
    input  logic              global_clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_pending,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (global_clk),
        .reset(reset),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk  (global_clk),
        .reset(reset),
        .din  (ss),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_state_t        state, state_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [DATA_W-2:0] rx_shift, rx_shift_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic [DATA_W-1:0] tx_buf, tx_buf_n;
    logic [DATA_W-1:0] rx_data_n, rx_word;
    logic              tx_pending_n, rx_valid_n, tx_underrun_n, frame_err_n, miso_n;
    logic              load_word;

    always_comb mosi_sync = mosi_q[SYNC_STAGES-1];

    always_ff @(posedge global_clk) begin
        if (!reset) begin
            mosi_q      <= '0;
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_pending  <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            miso        <= 1'b0;
        end else begin
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi};
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            rx_shift    <= rx_shift_n;
            tx_shift    <= tx_shift_n;
            tx_buf      <= tx_buf_n;
            tx_pending  <= tx_pending_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            tx_underrun <= tx_underrun_n;
            frame_err   <= frame_err_n;
            miso        <= miso_n;
        end
    end

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        rx_shift_n    = rx_shift;
        tx_shift_n    = tx_shift;
        tx_buf_n      = tx_buf;
        tx_pending_n  = tx_pending;
        rx_data_n     = rx_data;
        rx_valid_n    = 1'b0;
        tx_underrun_n = 1'b0;
        frame_err_n   = 1'b0;
        miso_n        = miso;
        load_word     = 1'b0;
        rx_word       = {rx_shift, mosi_sync};

        case (state)
            ST_IDLE: begin
                miso_n = 1'b0;
                if (ss_fall) begin
                    state_n   = ST_SHIFT;
                    bit_cnt_n = '0;
                    load_word = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise && bit_cnt != CNT_FULL) begin
                    rx_shift_n = rx_word[DATA_W-2:0];
                    bit_cnt_n  = bit_cnt + 1'b1;
                    if (bit_cnt_n == CNT_FULL) begin
                        rx_data_n  = rx_word;
                        rx_valid_n = 1'b1;
                    end
                end
                // ss rise wins over a coincident sclk fall, so a frame whose
                // last sclk fall lands with ss rise does not start another word.
                if (ss_rise) begin
                    state_n = ST_IDLE;
                    miso_n  = 1'b0;
                    if (bit_cnt_n != '0 && bit_cnt_n != CNT_FULL)
                        frame_err_n = 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt == CNT_FULL) begin
                        bit_cnt_n = '0;
                        load_word = 1'b1;
                    end else begin
                        tx_shift_n = tx_shift << 1;
                        miso_n     = tx_shift_n[DATA_W-1];
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (load_word) begin
            if (tx_pending) begin
                tx_shift_n   = tx_buf;
                tx_pending_n = 1'b0;
            end else begin
                tx_shift_n    = IDLE_TX;
                tx_underrun_n = 1'b1;
            end
            miso_n = tx_shift_n[DATA_W-1];
        end

        // A load coinciding with consumption queues the new word behind it.
        if (tx_load) begin
            tx_buf_n     = tx_data;
            tx_pending_n = 1'b1;
        end
    end

endmodule
